// File: rtl/wisc_pkg.sv
// Shared opcode map, datapath widths and flag-selection helpers for the WISC pipeline.
// No logic of its own; imported by the EX/MEM stage and its flag register.
// Helpers are pure functions of the opcode so they fold into simple decode.
package wisc_pkg;

    localparam int DW = 16;
    localparam int RW = 4;

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_XOR    = 4'h2;
    localparam logic [3:0] OP_RED    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LLB    = 4'hA;
    localparam logic [3:0] OP_LHB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_BR     = 4'hD;
    localparam logic [3:0] OP_PCS    = 4'hE;
    localparam logic [3:0] OP_HLT    = 4'hF;

    // ADD/SUB are the only ops whose adder produces meaningful V and N.
    function automatic logic sets_all_flags(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // Logic/shift ops report only zero; N and V stay from the last arithmetic op.
    function automatic logic sets_z_only(input logic [3:0] op);
        return (op == OP_XOR) || (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// Bundle of execute->memory stage signals plus the stage's registered outputs.
// Combinational wiring only; no latency of its own.
// stall/flush travel with the bundle; the master side (execute/hazard unit) drives them.
interface ex_mem_stage_if #(
    parameter int DW = 16,
    parameter int RW = 4
);
    logic          stall;
    logic          flush;
    logic          in_valid;
    logic [3:0]    in_opcode;
    logic [DW-1:0] in_result;
    logic          in_ovfl;
    logic [RW-1:0] in_rd;
    logic          in_reg_wr;
    logic          in_mem_rd;
    logic          in_mem_wr;
    logic [DW-1:0] in_store_data;

    logic          out_valid;
    logic [3:0]    out_opcode;
    logic [DW-1:0] out_result;
    logic [RW-1:0] out_rd;
    logic          out_reg_wr;
    logic          out_mem_rd;
    logic          out_mem_wr;
    logic [DW-1:0] out_store_data;
    logic          flag_z;
    logic          flag_v;
    logic          flag_n;
    logic          halted;

    modport master (
        output stall, flush, in_valid, in_opcode, in_result, in_ovfl, in_rd,
               in_reg_wr, in_mem_rd, in_mem_wr, in_store_data,
        input  out_valid, out_opcode, out_result, out_rd, out_reg_wr, out_mem_rd,
               out_mem_wr, out_store_data, flag_z, flag_v, flag_n, halted
    );

    modport slave (
        input  stall, flush, in_valid, in_opcode, in_result, in_ovfl, in_rd,
               in_reg_wr, in_mem_rd, in_mem_wr, in_store_data,
        output out_valid, out_opcode, out_result, out_rd, out_reg_wr, out_mem_rd,
               out_mem_wr, out_store_data, flag_z, flag_v, flag_n, halted
    );

endinterface

// File: rtl/ex_mem_stage_flag_reg.sv
// Architectural Z/V/N flag register, updated by the instruction captured into EX/MEM.
// Latency: 1 cycle; new flags are visible the cycle after en is high.
// No backpressure: the caller folds stall/flush/halt into en.
module flag_reg
    import wisc_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [3:0]    op,
    input  logic [DW-1:0] result,
    input  logic          ovfl,
    output logic          flag_z,
    output logic          flag_v,
    output logic          flag_n
);

    logic z_d, z_q;
    logic v_d, v_q;
    logic n_d, n_q;

    // Select which flags the captured opcode is allowed to overwrite.
    always_comb begin
        z_d = z_q;
        v_d = v_q;
        n_d = n_q;
        if (en) begin
            if (sets_all_flags(op)) begin
                z_d = (result == '0);
                v_d = ovfl;
                n_d = result[DW-1];
            end else if (sets_z_only(op)) begin
                z_d = (result == '0);
            end
        end
    end

    // Flag state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            z_q <= 1'b0;
            v_q <= 1'b0;
            n_q <= 1'b0;
        end else begin
            z_q <= z_d;
            v_q <= v_d;
            n_q <= n_d;
        end
    end

    assign flag_z = z_q;
    assign flag_v = v_q;
    assign flag_n = n_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures ALU result and controls, owns flags and sticky halt.
// Latency: 1 cycle from in_* to out_*; flags also visible 1 cycle after capture.
// stall holds everything (beats flush); flush, idle or halted inserts a bubble.
module ex_mem_stage
    import wisc_pkg::*;
#(
    parameter int DW = wisc_pkg::DW,
    parameter int RW = wisc_pkg::RW
) (
    input  logic          clk,
    input  logic          rst,
    ex_mem_stage_if.slave bus
);

    logic          cap;
    logic          valid_d,   valid_q;
    logic [3:0]    opcode_d,  opcode_q;
    logic [DW-1:0] result_d,  result_q;
    logic [RW-1:0] rd_d,      rd_q;
    logic          reg_wr_d,  reg_wr_q;
    logic          mem_rd_d,  mem_rd_q;
    logic          mem_wr_d,  mem_wr_q;
    logic [DW-1:0] sdata_d,   sdata_q;
    logic          halted_d,  halted_q;

    // Real instruction accepted this edge; flush and halt both turn it into a bubble.
    assign cap = bus.in_valid & ~bus.stall & ~bus.flush & ~halted_q;

    // Next-state mux: hold on stall, bubble controls otherwise unless capturing.
    always_comb begin
        valid_d  = valid_q;
        opcode_d = opcode_q;
        result_d = result_q;
        rd_d     = rd_q;
        reg_wr_d = reg_wr_q;
        mem_rd_d = mem_rd_q;
        mem_wr_d = mem_wr_q;
        sdata_d  = sdata_q;
        halted_d = halted_q;
        if (!bus.stall) begin
            valid_d  = cap;
            reg_wr_d = cap & bus.in_reg_wr;
            mem_rd_d = cap & bus.in_mem_rd;
            mem_wr_d = cap & bus.in_mem_wr;
            // Data fields are don't-care in a bubble, so they simply hold.
            if (cap) begin
                opcode_d = bus.in_opcode;
                result_d = bus.in_result;
                rd_d     = bus.in_rd;
                sdata_d  = bus.in_store_data;
                if (bus.in_opcode == OP_HLT) begin
                    halted_d = 1'b1;
                end
            end
        end
    end

    // Pipeline register bank with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            opcode_q <= '0;
            result_q <= '0;
            rd_q     <= '0;
            reg_wr_q <= 1'b0;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            sdata_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            opcode_q <= opcode_d;
            result_q <= result_d;
            rd_q     <= rd_d;
            reg_wr_q <= reg_wr_d;
            mem_rd_q <= mem_rd_d;
            mem_wr_q <= mem_wr_d;
            sdata_q  <= sdata_d;
            halted_q <= halted_d;
        end
    end

    flag_reg #(.DW(DW)) u_flag_reg (
        .clk    (clk),
        .rst    (rst),
        .en     (cap),
        .op     (bus.in_opcode),
        .result (bus.in_result),
        .ovfl   (bus.in_ovfl),
        .flag_z (bus.flag_z),
        .flag_v (bus.flag_v),
        .flag_n (bus.flag_n)
    );

    assign bus.out_valid      = valid_q;
    assign bus.out_opcode     = opcode_q;
    assign bus.out_result     = result_q;
    assign bus.out_rd         = rd_q;
    assign bus.out_reg_wr     = reg_wr_q;
    assign bus.out_mem_rd     = mem_rd_q;
    assign bus.out_mem_wr     = mem_wr_q;
    assign bus.out_store_data = sdata_q;
    assign bus.halted         = halted_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed vector bench for ex_mem_stage: one table row per clock, checked 1ns after the edge.
// Expected values are hand-computed from the stage's behaviour.
// Includes a hand-written stall-hold sequence after the table.
module tb_ex_mem_stage;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    ex_mem_stage_if #(.DW(16), .RW(4)) bus ();

    ex_mem_stage #(.DW(16), .RW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic        valid;
        logic [3:0]  op;
        logic [15:0] res;
        logic        ovfl;
        logic [3:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [15:0] sd;
        logic        e_valid;
        logic [3:0]  e_op;
        logic [15:0] e_res;
        logic [3:0]  e_rd;
        logic        e_rw;
        logic        e_mr;
        logic        e_mw;
        logic [15:0] e_sd;
        logic [2:0]  e_zvn;
        logic        e_halt;
        logic        chk_data;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(
        input logic r, input logic st, input logic fl, input logic v,
        input logic [3:0] op, input logic [15:0] res, input logic ov,
        input logic [3:0] rd, input logic rw, input logic mr, input logic mw,
        input logic [15:0] sd,
        input logic ev, input logic [3:0] eop, input logic [15:0] eres,
        input logic [3:0] erd, input logic erw, input logic emr, input logic emw,
        input logic [15:0] esd, input logic [2:0] ezvn, input logic eh,
        input logic cd);
        vec_t t;
        t.rst = r; t.stall = st; t.flush = fl; t.valid = v;
        t.op = op; t.res = res; t.ovfl = ov; t.rd = rd;
        t.rw = rw; t.mr = mr; t.mw = mw; t.sd = sd;
        t.e_valid = ev; t.e_op = eop; t.e_res = eres; t.e_rd = erd;
        t.e_rw = erw; t.e_mr = emr; t.e_mw = emw; t.e_sd = esd;
        t.e_zvn = ezvn; t.e_halt = eh; t.chk_data = cd;
        return t;
    endfunction

    task automatic check(input string name, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic st, input logic fl, input logic v,
                         input logic [3:0] op, input logic [15:0] res, input logic ov,
                         input logic [3:0] rd, input logic rw, input logic mr,
                         input logic mw, input logic [15:0] sd);
        rst               = r;
        bus.stall         = st;
        bus.flush         = fl;
        bus.in_valid      = v;
        bus.in_opcode     = op;
        bus.in_result     = res;
        bus.in_ovfl       = ov;
        bus.in_rd         = rd;
        bus.in_reg_wr     = rw;
        bus.in_mem_rd     = mr;
        bus.in_mem_wr     = mw;
        bus.in_store_data = sd;
    endtask

    task automatic check_outputs(input int row, input vec_t t);
        check("out_valid",  row, {31'd0, bus.out_valid},  {31'd0, t.e_valid});
        check("out_reg_wr", row, {31'd0, bus.out_reg_wr}, {31'd0, t.e_rw});
        check("out_mem_rd", row, {31'd0, bus.out_mem_rd}, {31'd0, t.e_mr});
        check("out_mem_wr", row, {31'd0, bus.out_mem_wr}, {31'd0, t.e_mw});
        check("flags_zvn",  row, {29'd0, bus.flag_z, bus.flag_v, bus.flag_n},
              {29'd0, t.e_zvn});
        check("halted",     row, {31'd0, bus.halted},     {31'd0, t.e_halt});
        if (t.chk_data) begin
            check("out_opcode",     row, {28'd0, bus.out_opcode},     {28'd0, t.e_op});
            check("out_result",     row, {16'd0, bus.out_result},     {16'd0, t.e_res});
            check("out_rd",         row, {28'd0, bus.out_rd},         {28'd0, t.e_rd});
            check("out_store_data", row, {16'd0, bus.out_store_data}, {16'd0, t.e_sd});
        end
    endtask

    initial begin
        vec_t h;
        errors = 0;
        checks = 0;
        //            rst st fl v  op     res       ov rd rw mr mw sd         | ev eop   eres      erd erw emr emw esd       zvn    h  cd
        vecs[0]  = mk(1, 0, 0, 0, 4'h0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000,   0, 4'h0, 16'h0000, 0, 0, 0, 0, 16'h0000, 3'b000, 0, 1);
        vecs[1]  = mk(1, 1, 1, 1, 4'hF, 16'h1111, 1, 5, 1, 1, 1, 16'h2222,   0, 4'h0, 16'h0000, 0, 0, 0, 0, 16'h0000, 3'b000, 0, 1);
        vecs[2]  = mk(0, 0, 0, 0, 4'h0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000,   0, 4'h0, 16'h0000, 0, 0, 0, 0, 16'h0000, 3'b000, 0, 0);
        // ADD: result 8000 with overflow -> Z=0 V=1 N=1
        vecs[3]  = mk(0, 0, 0, 1, 4'h0, 16'h8000, 1, 3, 1, 0, 0, 16'h0000,   1, 4'h0, 16'h8000, 3, 1, 0, 0, 16'h0000, 3'b011, 0, 1);
        // XOR zero: Z=1, V/N held
        vecs[4]  = mk(0, 0, 0, 1, 4'h2, 16'h0000, 0, 4, 1, 0, 0, 16'h0000,   1, 4'h2, 16'h0000, 4, 1, 0, 0, 16'h0000, 3'b111, 0, 1);
        // PADDSB never touches flags
        vecs[5]  = mk(0, 0, 0, 1, 4'h7, 16'h0000, 1, 5, 1, 0, 0, 16'h0000,   1, 4'h7, 16'h0000, 5, 1, 0, 0, 16'h0000, 3'b111, 0, 1);
        // SUB under stall: everything frozen
        vecs[6]  = mk(0, 1, 0, 1, 4'h1, 16'h0000, 0, 6, 1, 0, 0, 16'h0000,   1, 4'h7, 16'h0000, 5, 1, 0, 0, 16'h0000, 3'b111, 0, 1);
        vecs[7]  = mk(0, 1, 0, 1, 4'h1, 16'h0000, 0, 6, 1, 0, 0, 16'h0000,   1, 4'h7, 16'h0000, 5, 1, 0, 0, 16'h0000, 3'b111, 0, 1);
        vecs[8]  = mk(0, 1, 0, 1, 4'h1, 16'h0000, 0, 6, 1, 0, 0, 16'h0000,   1, 4'h7, 16'h0000, 5, 1, 0, 0, 16'h0000, 3'b111, 0, 1);
        // stall beats flush
        vecs[9]  = mk(0, 1, 1, 1, 4'h1, 16'h0000, 0, 6, 1, 0, 0, 16'h0000,   1, 4'h7, 16'h0000, 5, 1, 0, 0, 16'h0000, 3'b111, 0, 1);
        // flush alone -> bubble, flags hold
        vecs[10] = mk(0, 0, 1, 1, 4'h1, 16'h0000, 0, 6, 1, 1, 1, 16'h0000,   0, 4'h0, 16'h0000, 0, 0, 0, 0, 16'h0000, 3'b111, 0, 0);
        // SUB zero -> Z=1 V=0 N=0
        vecs[11] = mk(0, 0, 0, 1, 4'h1, 16'h0000, 0, 6, 1, 0, 0, 16'h0000,   1, 4'h1, 16'h0000, 6, 1, 0, 0, 16'h0000, 3'b100, 0, 1);
        // SRA 8000: Z=0, N stays 0 despite bit 15, V held
        vecs[12] = mk(0, 0, 0, 1, 4'h5, 16'h8000, 1, 7, 1, 0, 0, 16'h0000,   1, 4'h5, 16'h8000, 7, 1, 0, 0, 16'h0000, 3'b000, 0, 1);
        // back-to-back ROR zero -> Z=1
        vecs[13] = mk(0, 0, 0, 1, 4'h6, 16'h0000, 0, 8, 1, 0, 0, 16'h0000,   1, 4'h6, 16'h0000, 8, 1, 0, 0, 16'h0000, 3'b100, 0, 1);
        // SW pass-through
        vecs[14] = mk(0, 0, 0, 1, 4'h9, 16'h0040, 0, 0, 0, 0, 1, 16'hBEEF,   1, 4'h9, 16'h0040, 0, 0, 0, 1, 16'hBEEF, 3'b100, 0, 1);
        // LW with nonzero address: flags hold
        vecs[15] = mk(0, 0, 0, 1, 4'h8, 16'h0102, 1, 2, 1, 1, 0, 16'h0000,   1, 4'h8, 16'h0102, 2, 1, 1, 0, 16'h0000, 3'b100, 0, 1);
        vecs[16] = mk(0, 0, 0, 0, 4'h0, 16'h0000, 0, 0, 1, 1, 1, 16'h0000,   0, 4'h0, 16'h0000, 0, 0, 0, 0, 16'h0000, 3'b100, 0, 0);
        // HLT captured: visible once with out_valid=1, halted set
        vecs[17] = mk(0, 0, 0, 1, 4'hF, 16'h0000, 0, 0, 0, 0, 0, 16'h0000,   1, 4'hF, 16'h0000, 0, 0, 0, 0, 16'h0000, 3'b100, 1, 1);
        // after halt, ADDs are ignored
        vecs[18] = mk(0, 0, 0, 1, 4'h0, 16'h0000, 1, 1, 1, 0, 0, 16'h0000,   0, 4'h0, 16'h0000, 0, 0, 0, 0, 16'h0000, 3'b100, 1, 0);
        vecs[19] = mk(0, 0, 0, 1, 4'h0, 16'h8000, 1, 1, 1, 0, 0, 16'h0000,   0, 4'h0, 16'h0000, 0, 0, 0, 0, 16'h0000, 3'b100, 1, 0);
        // reset clears halt and flags
        vecs[20] = mk(1, 0, 0, 1, 4'h0, 16'h0000, 1, 1, 1, 0, 0, 16'h0000,   0, 4'h0, 16'h0000, 0, 0, 0, 0, 16'h0000, 3'b000, 0, 1);
        vecs[21] = mk(0, 0, 0, 1, 4'h0, 16'h1234, 0, 1, 1, 0, 0, 16'h0000,   1, 4'h0, 16'h1234, 1, 1, 0, 0, 16'h0000, 3'b000, 0, 1);

        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].valid, vecs[i].op,
                  vecs[i].res, vecs[i].ovfl, vecs[i].rd, vecs[i].rw, vecs[i].mr,
                  vecs[i].mw, vecs[i].sd);
            @(posedge clk);
            #1;
            check_outputs(i, vecs[i]);
        end

        // Hand sequence: ADD FFFF, then a two-cycle stall with a flag-writing XOR waiting.
        drive(0, 0, 0, 1, 4'h0, 16'hFFFF, 0, 9, 1, 0, 0, 16'h0000);
        @(posedge clk);
        #1;
        h = mk(0, 0, 0, 0, 4'h0, 16'h0, 0, 0, 0, 0, 0, 16'h0,
               1, 4'h0, 16'hFFFF, 9, 1, 0, 0, 16'h0000, 3'b001, 0, 1);
        check_outputs(100, h);
        for (int k = 0; k < 2; k++) begin
            drive(0, 1, 0, 1, 4'h2, 16'h0000, 0, 4, 1, 0, 0, 16'h0000);
            @(posedge clk);
            #1;
            check_outputs(101 + k, h);
        end
        // Stall released with nothing valid: bubble, flags still from the ADD.
        drive(0, 0, 0, 0, 4'h2, 16'h0000, 0, 4, 1, 0, 0, 16'h0000);
        @(posedge clk);
        #1;
        h.e_valid = 0; h.e_rw = 0; h.chk_data = 0;
        check_outputs(103, h);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
